pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer with a small hardware return stack. Each cycle
// one operation is sampled on the rising edge of clk. The operation either
// advances the PC, jumps, branches relative, calls (pushes a return address)
// or returns (pops it). Stack overflow and underflow are trapped without
// disturbing state and are recorded in sticky error flags.
//
// Parameters
//   WIDTH     : address width of the PC and of pc_in / offset / ret_top (>= 2)
//   DEPTH     : number of return-stack entries (1..16)
//   RESET_VEC : PC value forced while reset is low
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   stall    in   freezes PC, stack pointer, stack contents and error flags
//   op       in   operation code (NOP/INC/JMP/BR/CALL/RET/BRC, 111 = NOP)
//   cond     in   branch condition used by BRC
//   pc_in    in   absolute target for JMP and CALL
//   offset   in   two's-complement displacement for BR and BRC
//   err_clr  in   clears both sticky error flags (ignored while stalled)
//   pc_out   out  current program counter (registered)
//   sp       out  number of occupied stack entries (registered)
//   ret_top  out  top stack entry, 0 when the stack is empty
//   full     out  sp == DEPTH
//   empty    out  sp == 0
//   err_ovf  out  sticky overflow flag (CALL on a full stack)
//   err_unf  out  sticky underflow flag (RET on an empty stack)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                 WIDTH     = 4,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [2:0]                    op,
  input  logic                          cond,
  input  logic [WIDTH-1:0]              pc_in,
  input  logic [WIDTH-1:0]              offset,
  input  logic                          err_clr,
  output logic [WIDTH-1:0]              pc_out,
  output logic [$clog2(DEPTH+1)-1:0]    sp,
  output logic [WIDTH-1:0]              ret_top,
  output logic                          full,
  output logic                          empty,
  output logic                          err_ovf,
  output logic                          err_unf
);

  localparam int               SPW      = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0]   SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0]   SP_ZERO  = {SPW{1'b0}};
  localparam logic [SPW-1:0]   SP_ONE   = SPW'(1'b1);
  localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] PC_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_INC  = 3'b001,
    OP_JMP  = 3'b010,
    OP_BR   = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_BRC  = 3'b110,
    OP_RSV  = 3'b111
  } op_e;

  // Architectural state
  logic [WIDTH-1:0] pc_q,      pc_d;
  logic [SPW-1:0]   sp_q,      sp_d;
  logic             ovf_q,     ovf_d;
  logic             unf_q,     unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  // Decodes and per-cycle control
  logic             full_s;
  logic             empty_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] pc_rel_s;
  logic             push_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  op_e              op_s;

  assign op_s     = op_e'(op);
  assign full_s   = (sp_q == SP_FULL);
  assign empty_s  = (sp_q == SP_ZERO);

  // Same-width addition is already modulo 2^WIDTH, and a WIDTH-bit two's
  // complement offset added at WIDTH bits gives exactly the sign-extended sum.
  assign pc_inc_s = pc_q + PC_ONE;
  assign pc_rel_s = pc_q + offset;

  // Top-of-stack select: entry sp-1, or zero when the stack is empty.
  always_comb begin
    top_s = PC_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      top_s = top_s | (stack_q[i] & {WIDTH{(sp_q == SPW'(i + 1))}});
    end
  end

  // Next-state decode for PC and stack pointer, plus error-set requests.
  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (stall) begin
      pc_d = pc_q;
      sp_d = sp_q;
    end else begin
      case (op_s)
        OP_NOP: pc_d = pc_q;
        OP_INC: pc_d = pc_inc_s;
        OP_JMP: pc_d = pc_in;
        OP_BR:  pc_d = pc_rel_s;
        OP_CALL: begin
          if (full_s) begin
            // Overflow leaves PC, SP and the stack untouched.
            ovf_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
            sp_d   = sp_q + SP_ONE;
            pc_d   = pc_in;
          end
        end
        OP_RET: begin
          if (empty_s) begin
            unf_set_s = 1'b1;
          end else begin
            sp_d = sp_q - SP_ONE;
            pc_d = top_s;
          end
        end
        OP_BRC: pc_d = cond ? pc_rel_s : pc_inc_s;
        OP_RSV: pc_d = pc_q;
        default: pc_d = pc_q;
      endcase
    end
  end

  // Stack write: only the entry at index sp takes the return address on a push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = (push_s && (sp_q == SPW'(i))) ? pc_inc_s : stack_q[i];
    end
  end

  // Sticky error flags: a new error beats a coincident clear; stall holds both.
  always_comb begin
    if (stall) begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end else begin
      ovf_d = ovf_set_s | (ovf_q & ~err_clr);
      unf_d = unf_set_s | (unf_q & ~err_clr);
    end
  end

  // State registers; reset forces the PC to RESET_VEC and empties the stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= SP_ZERO;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= PC_ZERO;
      end
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign pc_out  = pc_q;
  assign sp      = sp_q;
  assign ret_top = top_s;
  assign full    = full_s;
  assign empty   = empty_s;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed self-checking bench for pc_sequencer (WIDTH=4, DEPTH=2,
// RESET_VEC=0). Inputs change 1 ns after a rising edge; outputs are checked
// 1 ns after the edge that consumed the operation.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] BR   = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;
  localparam logic [2:0] BRC  = 3'b110;
  localparam logic [2:0] RSV  = 3'b111;

  logic             clk;
  logic             reset;
  logic             stall;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] offset;
  logic             err_clr;
  logic [WIDTH-1:0] pc_out;
  logic [1:0]       sp;
  logic [WIDTH-1:0] ret_top;
  logic             full;
  logic             empty;
  logic             err_ovf;
  logic             err_unf;

  int n_cmp;
  int n_err;

  pc_sequencer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VEC (4'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .op      (op),
    .cond    (cond),
    .pc_in   (pc_in),
    .offset  (offset),
    .err_clr (err_clr),
    .pc_out  (pc_out),
    .sp      (sp),
    .ret_top (ret_top),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full visible state in one call.
  task automatic chk_all(input string tag, input logic [3:0] e_pc, input logic [1:0] e_sp,
                         input logic [3:0] e_top, input logic e_ovf, input logic e_unf);
    chk({tag, ".pc"},    {28'd0, pc_out},  {28'd0, e_pc});
    chk({tag, ".sp"},    {30'd0, sp},      {30'd0, e_sp});
    chk({tag, ".top"},   {28'd0, ret_top}, {28'd0, e_top});
    chk({tag, ".full"},  {31'd0, full},    {31'd0, (e_sp == 2'd2)});
    chk({tag, ".empty"}, {31'd0, empty},   {31'd0, (e_sp == 2'd0)});
    chk({tag, ".ovf"},   {31'd0, err_ovf}, {31'd0, e_ovf});
    chk({tag, ".unf"},   {31'd0, err_unf}, {31'd0, e_unf});
  endtask

  // Apply one operation for one clock edge, then settle to the check point.
  task automatic step(input logic [2:0] o, input logic [3:0] pin, input logic [3:0] off,
                      input logic c, input logic ec, input logic st);
    op      = o;
    pc_in   = pin;
    offset  = off;
    cond    = c;
    err_clr = ec;
    stall   = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    stall   = 1'b0;
    op      = NOP;
    cond    = 1'b0;
    pc_in   = 4'h0;
    offset  = 4'h0;
    err_clr = 1'b0;

    // Reset state before any clock edge, then still held across an edge.
    #3;
    chk_all("rst0", 4'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    op = INC;
    @(posedge clk);
    #1;
    chk_all("rst1", 4'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // Wrap: 16 INCs go 1..15,0.
    for (int i = 1; i <= 16; i++) begin
      step(INC, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("inc%0d", i), {28'd0, pc_out}, i % 16);
    end
    chk("wrap.sp", {30'd0, sp}, 32'd0);

    // NOP and reserved op hold.
    step(JMP, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("jmp3", {28'd0, pc_out}, 32'd3);
    step(NOP, 4'd9, 4'h5, 1'b1, 1'b0, 1'b0);
    chk("nop", {28'd0, pc_out}, 32'd3);
    step(RSV, 4'd9, 4'h5, 1'b1, 1'b0, 1'b0);
    chk("rsv", {28'd0, pc_out}, 32'd3);

    // Relative branches.
    step(BR, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
    chk("br_neg", {28'd0, pc_out}, 32'd1);
    step(BRC, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b0);
    chk("brc_nt", {28'd0, pc_out}, 32'd2);
    step(BRC, 4'h0, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("brc_t", {28'd0, pc_out}, 32'd6);
    step(JMP, 4'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    step(BR, 4'h0, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("br_m1", {28'd0, pc_out}, 32'd1);
    step(JMP, 4'd14, 4'h0, 1'b0, 1'b0, 1'b0);
    step(BR, 4'h0, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("br_wrap", {28'd0, pc_out}, 32'd1);

    // Nested call/return from pc=5.
    step(JMP, 4'd5, 4'h0, 1'b0, 1'b0, 1'b0);
    step(CALL, 4'd9, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("call1", 4'd9, 2'd1, 4'd6, 1'b0, 1'b0);
    step(CALL, 4'd12, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("call2", 4'd12, 2'd2, 4'd10, 1'b0, 1'b0);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("ret1", 4'd10, 2'd1, 4'd6, 1'b0, 1'b0);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("ret2", 4'd6, 2'd0, 4'd0, 1'b0, 1'b0);

    // Overflow: stack holds 7,10 then a third CALL is trapped.
    step(CALL, 4'd9, 4'h0, 1'b0, 1'b0, 1'b0);
    step(CALL, 4'd12, 4'h0, 1'b0, 1'b0, 1'b0);
    step(CALL, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("ovf", 4'd12, 2'd2, 4'd10, 1'b1, 1'b0);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("ovf.ret1", 4'd10, 2'd1, 4'd7, 1'b1, 1'b0);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("ovf.ret2", 4'd7, 2'd0, 4'd0, 1'b1, 1'b0);

    // Underflow, then clear coinciding with a fresh underflow, then clear alone.
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("unf", 4'd7, 2'd0, 4'd0, 1'b1, 1'b1);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk_all("clr+unf", 4'd7, 2'd0, 4'd0, 1'b0, 1'b1);
    step(NOP, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk_all("clr", 4'd7, 2'd0, 4'd0, 1'b0, 1'b0);

    // Stall: build sp=2 with err_ovf set, then stall CALL+err_clr for 3 cycles.
    step(CALL, 4'd9, 4'h0, 1'b0, 1'b0, 1'b0);
    step(CALL, 4'd11, 4'h0, 1'b0, 1'b0, 1'b0);
    step(CALL, 4'd4, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("pre_stall", 4'd11, 2'd2, 4'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(CALL, 4'd2, 4'h0, 1'b0, 1'b1, 1'b1);
      chk_all($sformatf("stall%0d", i), 4'd11, 2'd2, 4'd10, 1'b1, 1'b0);
    end
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("post_stall", 4'd10, 2'd1, 4'd8, 1'b1, 1'b0);

    // Async reset mid-cycle with sp=1, pc=9.
    step(JMP, 4'd9, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("pre_rst", 4'd9, 2'd1, 4'd8, 1'b1, 1'b0);
    op = INC;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    step(INC, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("after_rst", 4'd1, 2'd0, 4'd0, 1'b0, 1'b0);
    step(RET, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_all("rst_empty", 4'd1, 2'd0, 4'd0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
